// File: rtl/pong_pkg.sv
// Shared pong constants and types.
//   PADDLE_HOME          : paddle rest row used while the ball is receding
//   LIM_*                : paddle centre travel limits per bat size (shared
//                          with the button-based paddle controller)
//   ai_state_t           : computer-opponent sequencing states
//   press_dir_t          : which (if any) virtual button is held
//   lim_hi / lim_lo      : limit selection by bat_size (1 = small bat)
package pong_pkg;

  localparam logic [9:0] PADDLE_HOME  = 10'd240;
  localparam logic [9:0] LIM_SMALL_LO = 10'd40;
  localparam logic [9:0] LIM_SMALL_HI = 10'd440;
  localparam logic [9:0] LIM_LARGE_LO = 10'd50;
  localparam logic [9:0] LIM_LARGE_HI = 10'd430;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HOME  = 2'd1,
    ST_REACT = 2'd2,
    ST_TRACK = 2'd3
  } ai_state_t;

  // DOWN = increasing y (p2p held), UP = decreasing y (p2m held)
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_DOWN = 2'd1,
    DIR_UP   = 2'd2
  } press_dir_t;

  function automatic logic [9:0] lim_hi(input logic bat_size);
    return bat_size ? LIM_SMALL_HI : LIM_LARGE_HI;
  endfunction

  function automatic logic [9:0] lim_lo(input logic bat_size);
    return bat_size ? LIM_SMALL_LO : LIM_LARGE_LO;
  endfunction

endpackage

// File: rtl/ai_press_arbiter.sv
// Press arbiter for the computer paddle: owns the held-button register.
//   clk, rst  : clock, asynchronous active-low reset
//   active    : press logic enabled (HOME/TRACK and staying there)
//   err       : target - paddle centre, 11-bit signed
//   p2_y      : paddle centre, for limit gating
//   bat_size  : selects travel limits (1 = small bat)
//   p2p, p2m  : registered active-low increase-y / decrease-y presses
module ai_press_arbiter
  import pong_pkg::*;
#(
  parameter int DEAD = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic signed [10:0] err,
  input  logic [9:0]         p2_y,
  input  logic               bat_size,
  output logic               p2p,
  output logic               p2m
);

  localparam logic signed [10:0] DEAD_S = 11'(DEAD);

  press_dir_t dir;
  press_dir_t dir_nxt;

  always_comb begin
    dir_nxt = dir;
    if (!active) begin
      dir_nxt = DIR_NONE;
    end else begin
      case (dir)
        DIR_NONE: begin
          if (err > DEAD_S)       dir_nxt = DIR_DOWN;
          else if (err < -DEAD_S) dir_nxt = DIR_UP;
        end
        // A held press drops to NONE when reached or overshot; a reversal
        // always passes through one NONE cycle before the opposite press.
        DIR_DOWN: if (err <= 11'sd0) dir_nxt = DIR_NONE;
        DIR_UP:   if (err >= 11'sd0) dir_nxt = DIR_NONE;
        default:  dir_nxt = DIR_NONE;
      endcase
      if (dir_nxt == DIR_DOWN && p2_y >= lim_hi(bat_size)) dir_nxt = DIR_NONE;
      if (dir_nxt == DIR_UP   && p2_y <= lim_lo(bat_size)) dir_nxt = DIR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir <= DIR_NONE;
      p2p <= 1'b1;
      p2m <= 1'b1;
    end else begin
      dir <= dir_nxt;
      p2p <= !(dir_nxt == DIR_DOWN);
      p2m <= !(dir_nxt == DIR_UP);
    end
  end

endmodule

// File: rtl/paddle_ai_driver.sv
// Computer opponent for the right-hand paddle. Emits active-low button
// levels for the paddle controller: returns home while the ball recedes,
// tracks the ball after a reaction delay while it approaches.
//   clk, rst     : clock, asynchronous active-low reset
//   enable       : 1 = AI drives, 0 = both buttons released
//   ball_y       : ball centre row
//   ball_toward  : ball moving toward this paddle
//   p2_y         : paddle centre fed back from the controller
//   bat_size     : 1 = small bat, 0 = large bat
//   p2p, p2m     : active-low increase-y / decrease-y presses (registered)
module paddle_ai_driver
  import pong_pkg::*;
#(
  parameter int REACT_CYCLES = 2_000_000,
  parameter int DEAD         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [9:0] ball_y,
  input  logic       ball_toward,
  input  logic [9:0] p2_y,
  input  logic       bat_size,
  output logic       p2p,
  output logic       p2m
);

  localparam int CNT_W = (REACT_CYCLES > 1) ? $clog2(REACT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REACT_CYCLES - 1);

  ai_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [9:0]         target;
  logic signed [10:0] err;
  logic               active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_OFF;
      cnt   <= '0;
    end else if (!enable) begin
      state <= ST_OFF;
    end else begin
      case (state)
        ST_OFF: state <= ST_HOME;
        ST_HOME: begin
          if (ball_toward) begin
            state <= ST_REACT;
            cnt   <= CNT_LOAD;
          end
        end
        ST_REACT: begin
          // Ball turning away wins over the expiry of the delay.
          if (!ball_toward)   state <= ST_HOME;
          else if (cnt == '0) state <= ST_TRACK;
          else                cnt   <= cnt - 1'b1;
        end
        ST_TRACK: if (!ball_toward) state <= ST_HOME;
        default:  state <= ST_OFF;
      endcase
    end
  end

  assign target = (state == ST_TRACK) ? ball_y : PADDLE_HOME;
  // Widened before subtracting so the full +/-1023 range survives.
  assign err    = $signed({1'b0, target}) - $signed({1'b0, p2_y});

  // Presses only while staying in a pressing state; the edge that leaves
  // HOME for REACT or any edge with enable low clears the press.
  assign active = enable &&
                  ((state == ST_TRACK) || (state == ST_HOME && !ball_toward));

  ai_press_arbiter #(
    .DEAD (DEAD)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .err      (err),
    .p2_y     (p2_y),
    .bat_size (bat_size),
    .p2p      (p2p),
    .p2m      (p2m)
  );

endmodule

// File: tb/tb_paddle_ai_driver.sv
module tb_paddle_ai_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [9:0] ball_y;
  logic       ball_toward;
  logic [9:0] p2_y;
  logic       bat_size;
  logic       p2p;
  logic       p2m;

  int n_cmp = 0;
  int n_err = 0;
  logic       mon_on = 1'b0;
  logic [1:0] prev_o = 2'b11;

  paddle_ai_driver #(
    .REACT_CYCLES (4),
    .DEAD         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .ball_y      (ball_y),
    .ball_toward (ball_toward),
    .p2_y        (p2_y),
    .bat_size    (bat_size),
    .p2p         (p2p),
    .p2m         (p2m)
  );

  always #5 clk = ~clk;

  // {p2p, p2m} compared against expected pair
  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {p2p,p2m}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Invariants on every cycle: never both pressed, never a direct swap.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("never_both", {1'b0, ({p2p, p2m} == 2'b00)}, 2'b00);
      chk("no_direct_swap",
          {1'b0, ((prev_o == 2'b01 && {p2p, p2m} == 2'b10) ||
                  (prev_o == 2'b10 && {p2p, p2m} == 2'b01))}, 2'b00);
    end
    prev_o <= {p2p, p2m};
  end

  initial begin
    rst = 1'b1; enable = 1'b0; ball_y = '0; ball_toward = 1'b0;
    p2_y = 10'd240; bat_size = 1'b1;

    // 1. asynchronous reset with no clock edge, then idle while disabled
    #3 rst = 1'b0;
    #1 chk("rst_async", {p2p, p2m}, 2'b11);
    step(2);
    rst = 1'b1;
    mon_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("off_idle", {p2p, p2m}, 2'b11);
    end

    // 2. HOME from below: paddle at 300 must press decrease-y
    p2_y = 10'd300; enable = 1'b1;
    step(1); chk("home_entry", {p2p, p2m}, 2'b11);
    step(1); chk("home_press_up", {p2p, p2m}, 2'b10);
    p2_y = 10'd250; step(1); chk("home_hold_250", {p2p, p2m}, 2'b10);
    p2_y = 10'd241; step(1); chk("home_hold_241", {p2p, p2m}, 2'b10);
    p2_y = 10'd240; step(1); chk("home_reach", {p2p, p2m}, 2'b11);

    // 3. approach latency with REACT_CYCLES = 4
    ball_y = 10'd100; ball_toward = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step(1); chk("react_quiet", {p2p, p2m}, 2'b11);
    end
    step(1); chk("track_first_press", {p2p, p2m}, 2'b10);
    ball_toward = 1'b0;
    step(2); chk("back_home", {p2p, p2m}, 2'b11);
    // short pulse never tracks
    ball_toward = 1'b1; step(3);
    ball_toward = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1); chk("pulse_nopress", {p2p, p2m}, 2'b11);
    end

    // 4. deadband and hysteresis in TRACK
    ball_y = 10'd245; ball_toward = 1'b1;
    step(5);
    step(1); chk("track_dead_5", {p2p, p2m}, 2'b11);
    step(1); chk("track_dead_5b", {p2p, p2m}, 2'b11);
    ball_y = 10'd250;
    step(1); chk("track_down", {p2p, p2m}, 2'b01);
    for (int y = 241; y <= 249; y++) begin
      p2_y = 10'(y);
      step(1); chk("track_hyst_hold", {p2p, p2m}, 2'b01);
    end
    p2_y = 10'd250;
    step(1); chk("track_arrive", {p2p, p2m}, 2'b11);

    // 5. break-before-make on a reversal
    p2_y = 10'd240; ball_y = 10'd300;
    step(1); chk("bbm_down", {p2p, p2m}, 2'b01);
    ball_y = 10'd100;
    step(1); chk("bbm_gap", {p2p, p2m}, 2'b11);
    step(1); chk("bbm_up", {p2p, p2m}, 2'b10);

    // 6. limit gating
    bat_size = 1'b1; p2_y = 10'd440; ball_y = 10'd470;
    for (int i = 0; i < 3; i++) begin
      step(1); chk("lim_small_hi", {p2p, p2m}, 2'b11);
    end
    p2_y = 10'd439;
    step(1); chk("lim_small_hi_below", {p2p, p2m}, 2'b01);
    bat_size = 1'b0; p2_y = 10'd430;
    step(1); chk("lim_large_hi", {p2p, p2m}, 2'b11);
    p2_y = 10'd50; ball_y = 10'd0;
    for (int i = 0; i < 3; i++) begin
      step(1); chk("lim_large_lo", {p2p, p2m}, 2'b11);
    end
    p2_y = 10'd51;
    step(1); chk("lim_large_lo_above", {p2p, p2m}, 2'b10);
    bat_size = 1'b1; p2_y = 10'd40;
    step(1); chk("lim_small_lo", {p2p, p2m}, 2'b11);

    // mid-press disable releases after one edge
    p2_y = 10'd200;
    step(1); chk("pre_disable_press", {p2p, p2m}, 2'b10);
    enable = 1'b0;
    step(1); chk("disable_release", {p2p, p2m}, 2'b11);

    // mid-press asynchronous reset releases without an edge
    enable = 1'b1; ball_toward = 1'b0;
    step(2); chk("pre_rst_press", {p2p, p2m}, 2'b01);
    #2 rst = 1'b0;
    #1 chk("rst_midpress", {p2p, p2m}, 2'b11);
    step(2);
    chk("rst_held", {p2p, p2m}, 2'b11);
    rst = 1'b1;
    step(2);
    mon_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/paddle_ai_driver.md
# paddle_ai_driver

Computer opponent for the right-hand paddle. It produces the same active-low "up"/"down" button levels a player would press, and feeds them to the button-based paddle controller in place of the physical buttons. It reads back the controller's paddle centre `p2_y` and the ball position/direction, then steers the paddle: back to home when the ball is receding, and toward the ball after a reaction delay. Everything is registered; there are no combinational paths from inputs to outputs.

## Interface
- `REACT_CYCLES`, 2_000_000: delay from "ball approaching" to the start of tracking; must be ≥1.
- `DEAD`, 8: deadband in pixels; a press starts only when |error| > `DEAD`.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `enable` in 1: 1 = AI drives the paddle; 0 = both buttons released.
- `ball_y` in 10: ball centre row, pixels.
- `ball_toward` in 1: 1 = ball horizontal velocity points at this paddle.
- `p2_y` in 10: current paddle centre, fed back from the paddle controller.
- `bat_size` in 1: 1 = small bat (limits 40..440); 0 = large bat (limits 50..430).
- `p2p` out 1: active-low "increase y" press.
- `p2m` out 1: active-low "decrease y" press.

## Operation
- States: OFF, HOME, REACT, TRACK.
  - OFF: both outputs 1. `enable`=1 → HOME.
  - HOME: target = 240. `ball_toward`=1 → REACT, load `cnt` = `REACT_CYCLES`-1.
  - REACT: both outputs forced to 1. Decrement `cnt` each cycle.
    - `cnt`==0 → TRACK.
    - `ball_toward`=0 → HOME; this takes priority over the `cnt`==0 exit.
  - TRACK: target = `ball_y`. `ball_toward`=0 → HOME.
  - `enable`=0 in any state → OFF on the next edge; this has highest priority.
- Error: `err` = target − `p2_y`, 11-bit signed. Never truncate it to 10 bits.
- Press logic applies in HOME and TRACK. The press register `dir` ∈ {NONE, DOWN, UP}.
  - NONE: `err` > `DEAD` → DOWN. `err` < −`DEAD` → UP.
  - DOWN: hold while `err` > 0. `err` == 0 → NONE. `err` < 0 → NONE for one cycle (break-before-make), then re-evaluate.
  - UP: symmetric to DOWN.
  - The intermediate NONE cycle is mandatory, so `p2p` and `p2m` are never 0 in the same cycle, and never go from one 0 directly to the other 0.
- Limit gating, with limits selected by `bat_size`:
  - `p2_y` ≥ upper limit forces `p2p`=1.
  - `p2_y` ≤ lower limit forces `p2m`=1.
  - A gated direction sets `dir` to NONE.
- Outputs: `p2p` = !(`dir`==DOWN), `p2m` = !(`dir`==UP), both registered. Leaving HOME/TRACK sets `dir` to NONE.

## Timing
- Reset values: state OFF, `dir` NONE, `cnt` 0, `p2p`=1, `p2m`=1. Asserting `rst` mid-press releases both outputs immediately, because the reset is asynchronous.
- Output latency: 1 clock from the sampled inputs to `p2p`/`p2m`.
- Approach latency: `ball_toward` rises and is sampled at edge E0. TRACK is entered at E(`REACT_CYCLES`). The first press appears after E(`REACT_CYCLES`+1).
- A `ball_toward` glitch shorter than `REACT_CYCLES` never produces a tracking press.
- The paddle controller moves only once per 2^17 cycles. The driver therefore holds a level; it never pulses.
- Error is recomputed every cycle, so a `ball_y` jump is acted on the next cycle, subject to break-before-make.

## Structure
- Package `pong_pkg`:
  - `PADDLE_HOME`=240.
  - Limits: `LIM_SMALL_LO`=40, `LIM_SMALL_HI`=440, `LIM_LARGE_LO`=50, `LIM_LARGE_HI`=430.
  - State enum: `ai_state_t`.
  - Press enum: `press_dir_t`.
  - The paddle controller uses the same limit constants.
- Sub-module `ai_press_arbiter`: holds the `dir` register, hysteresis, break-before-make and limit gating. Its inputs are `err`, `p2_y`, `bat_size` and `active`. The top level holds the FSM, the reaction counter and target selection.

## Test plan
Bench uses `REACT_CYCLES`=4, `DEAD`=8.
1. `rst`=0 asserted with no clock edge → `p2p`=1, `p2m`=1 immediately. Release `rst` with `enable`=0 for 10 cycles → outputs stay 1.
2. `enable`=1, `ball_toward`=0, `p2_y`=300 → `p2m`=0 one cycle after HOME is entered. Step `p2_y` down to 240 → `p2m`=1 the cycle after `p2_y`==240.
3. HOME, `p2_y`=240, `ball_y`=100, `ball_toward` rises at E0 → outputs 1 through E4, `p2m`=0 after E5. Repeat with a 3-cycle `ball_toward` pulse → no press ever occurs.
4. TRACK, `p2_y`=240:
   - `ball_y`=245 → both outputs 1.
   - `ball_y`=250 → `p2p`=0.
   - `p2_y` stepped 241..249 → `p2p` held 0.
   - `p2_y`=250 → `p2p`=1.
5. TRACK pressing `p2p`, `ball_y` jumps to 100 → exactly one cycle with both outputs 1, then `p2m`=0. Assert `p2p`|`p2m` ≠ 0 on every cycle of the run.
6. Limit gating:
   - `bat_size`=1, `p2_y`=440, `ball_y`=470 → `p2p` stays 1.
   - `bat_size`=0, `p2_y`=50, `ball_y`=0 → `p2m` stays 1.
   - Mid-press `enable`=0 → both outputs 1 after the next edge.
